// File: rtl/d16_mem_responder_pkg.sv
// Shared constants for the d16 memory responder: I/O window base, register
// offsets and mailbox status bit positions.
package d16_mem_responder_pkg;

  localparam logic [3:0] D16_IO_BASE       = 4'hF;

  localparam logic [1:0] D16_IO_GPIO       = 2'd0;
  localparam logic [1:0] D16_IO_TIMER      = 2'd1;
  localparam logic [1:0] D16_IO_MBX_DATA   = 2'd2;
  localparam logic [1:0] D16_IO_MBX_STATUS = 2'd3;

  localparam int D16_STAT_FULL      = 0;
  localparam int D16_STAT_EMPTY     = 1;
  localparam int D16_STAT_OVF       = 2;
  localparam int D16_STAT_LEVEL_LSB = 4;

endpackage

// File: rtl/d16_mem_responder_fifo.sv
// d16_fifo: registered-storage FIFO without fall-through; a push is taken
// when not full or when a pop happens in the same cycle.
module d16_fifo #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [W-1:0]          push_data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/d16_mem_responder.sv
// Responder for the d16 instruction/data buses: IRAM, DRAM and an I/O window
// (GPIO, timer, mailbox). D16_MEM_LOADER_EN adds the ld_* IRAM write port.
module d16_mem_responder
  import d16_mem_responder_pkg::*;
#(
  parameter int IADDR_W        = 8,
  parameter int DADDR_W        = 10,
  parameter int MBX_DEPTH_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] ins_a,
  output logic [31:0] ins_di,
  input  logic [15:0] data_a,
  input  logic        data_we,
  input  logic [15:0] data_do,
  output logic [15:0] data_di,
  output logic [15:0] gpio_out,
  output logic [15:0] mbx_data,
  output logic        mbx_valid,
  input  logic        mbx_ready
`ifdef D16_MEM_LOADER_EN
  ,
  input  logic        ld_we,
  input  logic [15:0] ld_a,
  input  logic [31:0] ld_d
`endif
);

  logic [31:0]        iram_q [2**IADDR_W];
  logic [15:0]        dram_q [2**DADDR_W];
  logic               iram_we;
  logic [IADDR_W-1:0] iram_wa;
  logic [31:0]        iram_wd;
  logic               unused_bits;

  // Without the loader, IRAM contents come from the flow's memory image.
`ifdef D16_MEM_LOADER_EN
  assign iram_we     = ld_we;
  assign iram_wa     = ld_a[IADDR_W+1:2];
  assign iram_wd     = ld_d;
  assign unused_bits = ^{ins_a, data_a, ld_a};
`else
  assign iram_we     = 1'b0;
  assign iram_wa     = '0;
  assign iram_wd     = '0;
  assign unused_bits = ^{ins_a, data_a};
`endif

  logic [31:0] ins_di_q;
  logic [15:0] data_di_q, data_di_d, gpio_q, gpio_d, timer_q, timer_d, io_rdata, mbx_status;
  logic        ovf_q, ovf_d;
  logic        io_sel, io_we, mbx_push, mbx_pop, mbx_full, mbx_empty;
  logic [1:0]  io_off;
  logic [MBX_DEPTH_LOG2:0] mbx_level;

  assign io_sel    = (data_a[15:12] == D16_IO_BASE);
  assign io_off    = data_a[1:0];
  assign io_we     = data_we & io_sel;
  assign mbx_push  = io_we & (io_off == D16_IO_MBX_DATA);
  assign mbx_valid = ~mbx_empty;
  assign mbx_pop   = mbx_valid & mbx_ready;

  d16_fifo #(.W(16), .DEPTH_LOG2(MBX_DEPTH_LOG2)) u_mbx (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .push_i      (mbx_push),
    .push_data_i (data_do),
    .pop_i       (mbx_pop),
    .data_o      (mbx_data),
    .full_o      (mbx_full),
    .empty_o     (mbx_empty),
    .level_o     (mbx_level)
  );

  always_comb begin
    mbx_status = '0;
    mbx_status[D16_STAT_FULL]  = mbx_full;
    mbx_status[D16_STAT_EMPTY] = mbx_empty;
    mbx_status[D16_STAT_OVF]   = ovf_q;
    mbx_status[D16_STAT_LEVEL_LSB +: 4] = 4'(mbx_level);
  end

  // Reads see register values from before this cycle's write.
  always_comb begin
    case (io_off)
      D16_IO_GPIO:     io_rdata = gpio_q;
      D16_IO_TIMER:    io_rdata = timer_q;
      D16_IO_MBX_DATA: io_rdata = mbx_data;
      default:         io_rdata = mbx_status;
    endcase
    data_di_d = io_sel ? io_rdata : dram_q[data_a[DADDR_W-1:0]];
  end

  always_comb begin
    gpio_d  = gpio_q;
    timer_d = timer_q + 16'd1;
    ovf_d   = ovf_q;
    if (io_we && io_off == D16_IO_GPIO)  gpio_d  = data_do;
    if (io_we && io_off == D16_IO_TIMER) timer_d = data_do;
    if (io_we && io_off == D16_IO_MBX_STATUS) ovf_d = 1'b0;
    else if (mbx_push && mbx_full && !mbx_pop) ovf_d = 1'b1;
  end

  // RAM writes are deliberately outside reset so a write coincident with reset lands.
  always_ff @(posedge sys_clk) begin
    if (iram_we) iram_q[iram_wa] <= iram_wd;
    if (data_we && !io_sel) dram_q[data_a[DADDR_W-1:0]] <= data_do;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ins_di_q  <= '0;
      data_di_q <= '0;
      gpio_q    <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ins_di_q  <= iram_q[ins_a[IADDR_W+1:2]];
      data_di_q <= data_di_d;
      gpio_q    <= gpio_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ins_di   = ins_di_q;
  assign data_di  = data_di_q;
  assign gpio_out = gpio_q;

endmodule
